// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I$ and D$ miss traffic
// for every hardware thread, with per-source/per-thread request slots and a response watchdog.
module memory_arbiter #(
    parameter int THR_PER_CORE = 2,
    parameter int ADDR_WIDTH   = 26,
    parameter int LINE_WIDTH   = 128,
    parameter int TIMEOUT      = 64,
    parameter int THR_W        = (THR_PER_CORE > 1) ? $clog2(THR_PER_CORE) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    input  logic [THR_W-1:0]      ic_req_thread_id,
    output logic                  ic_rsp_valid,
    output logic [LINE_WIDTH-1:0] ic_rsp_data,
    output logic                  ic_rsp_bus_error,
    output logic [THR_W-1:0]      ic_rsp_thread_id,
    input  logic                  dc_req_valid,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic                  dc_req_is_store,
    input  logic [LINE_WIDTH-1:0] dc_req_data,
    input  logic [THR_W-1:0]      dc_req_thread_id,
    output logic                  dc_rsp_valid,
    output logic [LINE_WIDTH-1:0] dc_rsp_data,
    output logic                  dc_rsp_bus_error,
    output logic [THR_W-1:0]      dc_rsp_thread_id,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_is_store,
    output logic [LINE_WIDTH-1:0] mem_req_data,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data,
    input  logic                  mem_rsp_bus_error,
    output logic                  proto_error
);

    localparam int unsigned THR_N  = THR_PER_CORE;
    localparam int unsigned NSLOT  = 2 * THR_PER_CORE;
    localparam int          SLOT_W = $clog2(NSLOT);
    localparam int          WDOG_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]                        state_q, state_d;
    logic [SLOT_W-1:0]                 cur_q, cur_d;
    logic [SLOT_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [WDOG_W-1:0]                 wdog_q, wdog_d;
    logic [NSLOT-1:0]                  slot_valid_q, slot_valid_d;
    logic [NSLOT-1:0][ADDR_WIDTH-1:0]  slot_addr_q, slot_addr_d;
    logic [NSLOT-1:0]                  slot_store_q, slot_store_d;
    logic [NSLOT-1:0][LINE_WIDTH-1:0]  slot_data_q, slot_data_d;
    logic                              proto_error_q, proto_error_d;
    logic                              ic_rsp_valid_q, ic_rsp_valid_d;
    logic [LINE_WIDTH-1:0]             ic_rsp_data_q, ic_rsp_data_d;
    logic                              ic_rsp_bus_error_q, ic_rsp_bus_error_d;
    logic [THR_W-1:0]                  ic_rsp_thread_id_q, ic_rsp_thread_id_d;
    logic                              dc_rsp_valid_q, dc_rsp_valid_d;
    logic [LINE_WIDTH-1:0]             dc_rsp_data_q, dc_rsp_data_d;
    logic                              dc_rsp_bus_error_q, dc_rsp_bus_error_d;
    logic [THR_W-1:0]                  dc_rsp_thread_id_q, dc_rsp_thread_id_d;

    logic                  pick_found;
    logic [SLOT_W-1:0]     pick_idx;
    int unsigned           cand;
    logic                  finish, fin_err, cur_is_ic;
    logic [THR_W-1:0]      rsp_thr;
    logic [LINE_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic [SLOT_W-1:0]     ic_slot, dc_slot;

    // First valid slot at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            cand = (32'(rr_ptr_q) + i) % NSLOT;
            if (!pick_found && slot_valid_q[cand[SLOT_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[SLOT_W-1:0];
            end
        end
    end

    assign cur_is_ic = 32'(cur_q) < THR_N;
    assign rsp_thr   = THR_W'(32'(cur_q) % THR_N);
    assign ic_slot   = SLOT_W'(ic_req_thread_id);
    assign dc_slot   = SLOT_W'(THR_N + 32'(dc_req_thread_id));

    always_comb begin
        state_d            = state_q;
        cur_d              = cur_q;
        rr_ptr_d           = rr_ptr_q;
        wdog_d             = wdog_q;
        slot_valid_d       = slot_valid_q;
        slot_addr_d        = slot_addr_q;
        slot_store_d       = slot_store_q;
        slot_data_d        = slot_data_q;
        proto_error_d      = proto_error_q;
        ic_rsp_valid_d     = 1'b0;
        ic_rsp_data_d      = '0;
        ic_rsp_bus_error_d = 1'b0;
        ic_rsp_thread_id_d = '0;
        dc_rsp_valid_d     = 1'b0;
        dc_rsp_data_d      = '0;
        dc_rsp_bus_error_d = 1'b0;
        dc_rsp_thread_id_d = '0;
        finish             = 1'b0;
        fin_err            = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    cur_d   = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    wdog_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (mem_rsp_valid) begin
                    finish = 1'b1;
                end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        rsp_data = fin_err ? '0 : mem_rsp_data;
        rsp_err  = fin_err | mem_rsp_bus_error;
        if (finish) begin
            slot_valid_d[cur_q] = 1'b0;
            rr_ptr_d = (32'(cur_q) == NSLOT - 1) ? '0 : cur_q + 1'b1;
            wdog_d   = '0;
            state_d  = IDLE;
            if (cur_is_ic) begin
                ic_rsp_valid_d     = 1'b1;
                ic_rsp_data_d      = rsp_data;
                ic_rsp_bus_error_d = rsp_err;
                ic_rsp_thread_id_d = rsp_thr;
            end else begin
                dc_rsp_valid_d     = 1'b1;
                dc_rsp_data_d      = rsp_data;
                dc_rsp_bus_error_d = rsp_err;
                dc_rsp_thread_id_d = rsp_thr;
            end
        end

        // Occupancy is judged after the response clear, so a same-cycle capture wins.
        if (ic_req_valid) begin
            if (slot_valid_d[ic_slot]) begin
                proto_error_d = 1'b1;
            end else begin
                slot_valid_d[ic_slot] = 1'b1;
                slot_addr_d[ic_slot]  = ic_req_addr;
                slot_store_d[ic_slot] = 1'b0;
                slot_data_d[ic_slot]  = '0;
            end
        end
        if (dc_req_valid) begin
            if (slot_valid_d[dc_slot]) begin
                proto_error_d = 1'b1;
            end else begin
                slot_valid_d[dc_slot] = 1'b1;
                slot_addr_d[dc_slot]  = dc_req_addr;
                slot_store_d[dc_slot] = dc_req_is_store;
                slot_data_d[dc_slot]  = dc_req_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            cur_q              <= '0;
            rr_ptr_q           <= '0;
            wdog_q             <= '0;
            slot_valid_q       <= '0;
            slot_addr_q        <= '0;
            slot_store_q       <= '0;
            slot_data_q        <= '0;
            proto_error_q      <= 1'b0;
            ic_rsp_valid_q     <= 1'b0;
            ic_rsp_data_q      <= '0;
            ic_rsp_bus_error_q <= 1'b0;
            ic_rsp_thread_id_q <= '0;
            dc_rsp_valid_q     <= 1'b0;
            dc_rsp_data_q      <= '0;
            dc_rsp_bus_error_q <= 1'b0;
            dc_rsp_thread_id_q <= '0;
        end else begin
            state_q            <= state_d;
            cur_q              <= cur_d;
            rr_ptr_q           <= rr_ptr_d;
            wdog_q             <= wdog_d;
            slot_valid_q       <= slot_valid_d;
            slot_addr_q        <= slot_addr_d;
            slot_store_q       <= slot_store_d;
            slot_data_q        <= slot_data_d;
            proto_error_q      <= proto_error_d;
            ic_rsp_valid_q     <= ic_rsp_valid_d;
            ic_rsp_data_q      <= ic_rsp_data_d;
            ic_rsp_bus_error_q <= ic_rsp_bus_error_d;
            ic_rsp_thread_id_q <= ic_rsp_thread_id_d;
            dc_rsp_valid_q     <= dc_rsp_valid_d;
            dc_rsp_data_q      <= dc_rsp_data_d;
            dc_rsp_bus_error_q <= dc_rsp_bus_error_d;
            dc_rsp_thread_id_q <= dc_rsp_thread_id_d;
        end
    end

    assign mem_req_valid    = (state_q == ISSUE);
    assign mem_req_addr     = mem_req_valid ? slot_addr_q[cur_q] : '0;
    assign mem_req_is_store = mem_req_valid & slot_store_q[cur_q];
    assign mem_req_data     = mem_req_valid ? slot_data_q[cur_q] : '0;

    assign ic_rsp_valid     = ic_rsp_valid_q;
    assign ic_rsp_data      = ic_rsp_data_q;
    assign ic_rsp_bus_error = ic_rsp_bus_error_q;
    assign ic_rsp_thread_id = ic_rsp_thread_id_q;
    assign dc_rsp_valid     = dc_rsp_valid_q;
    assign dc_rsp_data      = dc_rsp_data_q;
    assign dc_rsp_bus_error = dc_rsp_bus_error_q;
    assign dc_rsp_thread_id = dc_rsp_thread_id_q;
    assign proto_error      = proto_error_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter: latency, ordering, backpressure,
// watchdog and protocol-error/reset behaviour with hand-computed expectations.
module tb_memory_arbiter;

    localparam int AW = 26;
    localparam int LW = 128;
    localparam int TW = 1;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req_valid = 1'b0;
    logic [AW-1:0] ic_req_addr = '0;
    logic [TW-1:0] ic_req_thread_id = '0;
    logic          ic_rsp_valid;
    logic [LW-1:0] ic_rsp_data;
    logic          ic_rsp_bus_error;
    logic [TW-1:0] ic_rsp_thread_id;
    logic          dc_req_valid = 1'b0;
    logic [AW-1:0] dc_req_addr = '0;
    logic          dc_req_is_store = 1'b0;
    logic [LW-1:0] dc_req_data = '0;
    logic [TW-1:0] dc_req_thread_id = '0;
    logic          dc_rsp_valid;
    logic [LW-1:0] dc_rsp_data;
    logic          dc_rsp_bus_error;
    logic [TW-1:0] dc_rsp_thread_id;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_is_store;
    logic [LW-1:0] mem_req_data;
    logic          mem_req_ready = 1'b0;
    logic          mem_rsp_valid = 1'b0;
    logic [LW-1:0] mem_rsp_data = '0;
    logic          mem_rsp_bus_error = 1'b0;
    logic          proto_error;

    int n_checks = 0;
    int n_pass   = 0;

    memory_arbiter #(
        .THR_PER_CORE(2),
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_thread_id(ic_req_thread_id),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
        .ic_rsp_bus_error(ic_rsp_bus_error), .ic_rsp_thread_id(ic_rsp_thread_id),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_is_store(dc_req_is_store),
        .dc_req_data(dc_req_data), .dc_req_thread_id(dc_req_thread_id),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
        .dc_rsp_bus_error(dc_rsp_bus_error), .dc_rsp_thread_id(dc_rsp_thread_id),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_is_store(mem_req_is_store), .mem_req_data(mem_req_data),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_bus_error(mem_rsp_bus_error),
        .proto_error(proto_error)
    );

    always #5 clock = ~clock;

    // Advance one cycle; drive and sample 2 time units after the rising edge.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        step();
        step();
        got = {mem_req_valid, ic_rsp_valid, dc_rsp_valid, proto_error};
        n_checks++;
        if (got !== 4'b0) $display("FAIL reset_flags: got %b expected %b", got, 4'b0);
        else n_pass++;
        n_checks++;
        if ({mem_req_addr, mem_req_is_store, mem_req_data} !== '0)
            $display("FAIL reset_req_fields: got %h expected 0", {mem_req_addr, mem_req_is_store, mem_req_data});
        else n_pass++;
        reset = 1'b0;
        step();
        n_checks++;
        if (mem_req_valid !== 1'b0) $display("FAIL idle_after_reset: got %b expected 0", mem_req_valid);
        else n_pass++;
    endtask

    task automatic test_single_ic_miss();
        logic [LW-1:0] aa;
        int dc_seen;
        aa = {16{8'hAA}};
        dc_seen = 0;
        ic_req_valid = 1'b1; ic_req_addr = 26'h100; ic_req_thread_id = 1'b1;
        step();
        ic_req_valid = 1'b0;
        n_checks++;
        if (mem_req_valid !== 1'b0) $display("FAIL single_c1_idle: got %b expected 0", mem_req_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data} !== {1'b1, 26'h100, 1'b0, 128'h0})
            $display("FAIL single_issue_c2: got v=%b a=%h s=%b d=%h expected v=1 a=100 s=0 d=0",
                     mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data);
        else n_pass++;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int c = 3; c < 10; c++) begin
            if (ic_rsp_valid !== 1'b0 || dc_rsp_valid !== 1'b0) dc_seen++;
            step();
        end
        n_checks++;
        if (dc_seen !== 0) $display("FAIL single_early_rsp: got %0d early pulses expected 0", dc_seen);
        else n_pass++;
        mem_rsp_valid = 1'b1; mem_rsp_data = aa;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        n_checks++;
        if ({ic_rsp_valid, ic_rsp_thread_id, ic_rsp_bus_error, ic_rsp_data} !== {1'b1, 1'b1, 1'b0, aa})
            $display("FAIL single_ic_rsp_c11: got v=%b t=%b e=%b d=%h expected v=1 t=1 e=0 d=%h",
                     ic_rsp_valid, ic_rsp_thread_id, ic_rsp_bus_error, ic_rsp_data, aa);
        else n_pass++;
        n_checks++;
        if (dc_rsp_valid !== 1'b0) $display("FAIL single_dc_quiet: got %b expected 0", dc_rsp_valid);
        else n_pass++;
        step();
        n_checks++;
        if (ic_rsp_valid !== 1'b0) $display("FAIL single_rsp_pulse: got %b expected 0", ic_rsp_valid);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [LW-1:0] st_data, rd_data;
        st_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        rd_data = 128'h5555_0000_5555_0000_5555_0000_5555_0000;
        do_reset();
        ic_req_valid = 1'b1; ic_req_addr = 26'h200; ic_req_thread_id = 1'b0;
        dc_req_valid = 1'b1; dc_req_addr = 26'h300; dc_req_thread_id = 1'b1;
        dc_req_is_store = 1'b1; dc_req_data = st_data;
        step();
        ic_req_valid = 1'b0; dc_req_valid = 1'b0; dc_req_is_store = 1'b0; dc_req_data = '0;
        step();
        n_checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_is_store} !== {1'b1, 26'h200, 1'b0})
            $display("FAIL sim_ic_first: got v=%b a=%h s=%b expected v=1 a=200 s=0",
                     mem_req_valid, mem_req_addr, mem_req_is_store);
        else n_pass++;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = rd_data;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        n_checks++;
        if ({ic_rsp_valid, ic_rsp_thread_id, mem_req_valid} !== {1'b1, 1'b0, 1'b0})
            $display("FAIL sim_ic_rsp: got rsp=%b t=%b req=%b expected rsp=1 t=0 req=0",
                     ic_rsp_valid, ic_rsp_thread_id, mem_req_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data} !== {1'b1, 26'h300, 1'b1, st_data})
            $display("FAIL sim_dc_store_issue: got v=%b a=%h s=%b d=%h expected v=1 a=300 s=1 d=%h",
                     mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data, st_data);
        else n_pass++;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = rd_data;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        n_checks++;
        if ({dc_rsp_valid, dc_rsp_thread_id, dc_rsp_data, ic_rsp_valid} !== {1'b1, 1'b1, rd_data, 1'b0})
            $display("FAIL sim_dc_store_rsp: got v=%b t=%b d=%h ic=%b expected v=1 t=1 d=%h ic=0",
                     dc_rsp_valid, dc_rsp_thread_id, dc_rsp_data, ic_rsp_valid, rd_data);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int s, waited;
        logic [AW-1:0] exp_addr;
        logic [2:0] exp_rsp, got_rsp;
        do_reset();
        ic_req_valid = 1'b1; ic_req_addr = 26'h0000; ic_req_thread_id = 1'b0;
        dc_req_valid = 1'b1; dc_req_addr = 26'h2000; dc_req_thread_id = 1'b0;
        step();
        ic_req_addr = 26'h1000; ic_req_thread_id = 1'b1;
        dc_req_addr = 26'h3000; dc_req_thread_id = 1'b1;
        step();
        ic_req_valid = 1'b0; dc_req_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            s = n % 4;
            exp_addr = AW'(s * 'h1000 + n / 4);
            waited = 0;
            while (mem_req_valid !== 1'b1 && waited < 20) begin
                step();
                waited++;
            end
            n_checks++;
            if ({mem_req_valid, mem_req_addr} !== {1'b1, exp_addr})
                $display("FAIL rr_grant_%0d: got v=%b a=%h expected v=1 a=%h", n, mem_req_valid, mem_req_addr, exp_addr);
            else n_pass++;
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1; mem_rsp_data = LW'(n);
            if (s < 2) begin
                ic_req_valid = 1'b1; ic_req_thread_id = TW'(s % 2);
                ic_req_addr = AW'(s * 'h1000 + n / 4 + 1);
            end else begin
                dc_req_valid = 1'b1; dc_req_thread_id = TW'(s % 2);
                dc_req_addr = AW'(s * 'h1000 + n / 4 + 1);
            end
            step();
            mem_rsp_valid = 1'b0; ic_req_valid = 1'b0; dc_req_valid = 1'b0;
            exp_rsp = (s < 2) ? {1'b1, 1'b0, TW'(s % 2)} : {1'b0, 1'b1, TW'(s % 2)};
            got_rsp = (s < 2) ? {ic_rsp_valid, dc_rsp_valid, ic_rsp_thread_id}
                              : {ic_rsp_valid, dc_rsp_valid, dc_rsp_thread_id};
            n_checks++;
            if (got_rsp !== exp_rsp)
                $display("FAIL rr_route_%0d: got ic/dc/t=%b expected %b", n, got_rsp, exp_rsp);
            else n_pass++;
        end
        n_checks++;
        if (proto_error !== 1'b0) $display("FAIL rr_same_cycle_refill: got proto_error=%b expected 0", proto_error);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [LW-1:0] d;
        logic [AW+LW+1:0] exp_req;
        d = {4{32'hC0DE_0001}};
        do_reset();
        dc_req_valid = 1'b1; dc_req_addr = 26'h55; dc_req_thread_id = 1'b0;
        dc_req_is_store = 1'b1; dc_req_data = d;
        step();
        dc_req_valid = 1'b0; dc_req_is_store = 1'b0; dc_req_data = '0;
        step();
        exp_req = {1'b1, 26'h55, 1'b1, d};
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if ({mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data} !== exp_req)
                $display("FAIL bp_stable_%0d: got %h expected %h", c,
                         {mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data}, exp_req);
            else n_pass++;
            mem_req_ready = (c == 5);
            step();
        end
        mem_req_ready = 1'b0;
        n_checks++;
        if (mem_req_valid !== 1'b0) $display("FAIL bp_wait: got %b expected 0", mem_req_valid);
        else n_pass++;
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        n_checks++;
        if ({dc_rsp_valid, dc_rsp_thread_id} !== 2'b10)
            $display("FAIL bp_rsp: got v/t=%b expected 10", {dc_rsp_valid, dc_rsp_thread_id});
        else n_pass++;
    endtask

    task automatic test_watchdog();
        int early, extra;
        early = 0;
        extra = 0;
        do_reset();
        dc_req_valid = 1'b1; dc_req_addr = 26'h77; dc_req_thread_id = 1'b1;
        dc_req_is_store = 1'b1; dc_req_data = {4{32'h1111_2222}};
        step();
        dc_req_valid = 1'b0; dc_req_is_store = 1'b0; dc_req_data = '0;
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_data = '1;
        for (int c = 3; c <= 10; c++) begin
            if (dc_rsp_valid !== 1'b0) early++;
            step();
        end
        n_checks++;
        if (early !== 0) $display("FAIL wd_early: got %0d pulses expected 0", early);
        else n_pass++;
        n_checks++;
        if ({dc_rsp_valid, dc_rsp_bus_error, dc_rsp_thread_id, dc_rsp_data} !== {1'b1, 1'b1, 1'b1, 128'h0})
            $display("FAIL wd_bus_error: got v=%b e=%b t=%b d=%h expected v=1 e=1 t=1 d=0",
                     dc_rsp_valid, dc_rsp_bus_error, dc_rsp_thread_id, dc_rsp_data);
        else n_pass++;
        step();
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        for (int c = 0; c < 5; c++) begin
            if (dc_rsp_valid !== 1'b0 || ic_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) extra++;
            step();
        end
        n_checks++;
        if (extra !== 0) $display("FAIL wd_late_rsp_ignored: got %0d active cycles expected 0", extra);
        else n_pass++;
    endtask

    task automatic test_proto_and_reset();
        int extra;
        extra = 0;
        do_reset();
        ic_req_valid = 1'b1; ic_req_addr = 26'h123; ic_req_thread_id = 1'b0;
        step();
        ic_req_addr = 26'h456;
        n_checks++;
        if (proto_error !== 1'b0) $display("FAIL proto_before: got %b expected 0", proto_error);
        else n_pass++;
        step();
        ic_req_valid = 1'b0;
        n_checks++;
        if ({proto_error, mem_req_valid, mem_req_addr} !== {1'b1, 1'b1, 26'h123})
            $display("FAIL proto_set_addr_kept: got pe=%b v=%b a=%h expected pe=1 v=1 a=123",
                     proto_error, mem_req_valid, mem_req_addr);
        else n_pass++;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({proto_error, mem_req_valid, ic_rsp_valid, dc_rsp_valid, mem_req_addr} !== '0)
            $display("FAIL reset_in_wait: got pe=%b v=%b ic=%b dc=%b a=%h expected all 0",
                     proto_error, mem_req_valid, ic_rsp_valid, dc_rsp_valid, mem_req_addr);
        else n_pass++;
        step();
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (ic_rsp_valid !== 1'b0 || dc_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || proto_error !== 1'b0)
                extra++;
            step();
        end
        n_checks++;
        if (extra !== 0) $display("FAIL reset_abandons: got %0d active cycles expected 0", extra);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_ic_miss();
        test_simultaneous();
        test_round_robin();
        test_backpressure();
        test_watchdog();
        test_proto_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
